// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared types and constants for the RV32IM pipelined control
//               decoder: opcodes, ALU op codes, control word, FSM states.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package ctrl_pkg;

    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ICALC  = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;

    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;
    localparam logic [6:0] c_F7_MEXT = 7'b0000001;

    typedef enum logic [4:0] {
        ALU_AND   = 5'd0,  ALU_OR    = 5'd1,  ALU_ADD  = 5'd2,  ALU_MUL  = 5'd3,
        ALU_MULU  = 5'd4,  ALU_DIV   = 5'd5,  ALU_DIVU = 5'd6,  ALU_REM  = 5'd7,
        ALU_REMU  = 5'd8,  ALU_SUB   = 5'd9,  ALU_SLT  = 5'd10, ALU_SLTU = 5'd11,
        ALU_XOR   = 5'd12, ALU_SLL   = 5'd13, ALU_SRA  = 5'd14, ALU_SRL  = 5'd15,
        ALU_BEQ   = 5'd16, ALU_BNE   = 5'd17, ALU_BLT  = 5'd18, ALU_BLTU = 5'd19,
        ALU_BGE   = 5'd20, ALU_BGEU  = 5'd21, ALU_JALR = 5'd22, ALU_JAL  = 5'd23,
        ALU_AUIPC = 5'd24, ALU_LUI   = 5'd25, ALU_NOP  = 5'd26
    } alu_op_e;

    typedef struct packed {
        logic    branch;
        logic    mem_read;
        logic    mem_to_reg;
        logic    mem_write;
        logic    alu_src;
        logic    reg_write;
        logic    illegal;
        alu_op_e alu_ctrl;
    } ctrl_word_t;

    localparam ctrl_word_t c_BUBBLE = '{
        branch: 1'b0, mem_read: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0,
        alu_src: 1'b0, reg_write: 1'b0, illegal: 1'b0, alu_ctrl: ALU_NOP
    };

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_MD_WAIT = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/ctrl_decode_pipe_if.sv
// ============================================================================
// Module      : ctrl_decode_pipe_if
// Description : Instruction-in / control-out handshake plus mul/div sequencing
//               bus of the pipelined control decoder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface ctrl_decode_pipe_if #(
    parameter int XLEN      = 32,
    parameter int ALUCTRL_W = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [XLEN-1:0]      instr;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic                 branch;
    logic                 mem_read;
    logic                 mem_to_reg;
    logic                 mem_write;
    logic                 alu_src;
    logic                 reg_write;
    logic [ALUCTRL_W-1:0] alu_ctrl;
    logic                 illegal;
    logic                 md_start;
    logic                 md_abort;
    logic                 md_done;

    modport slave (
        input  in_valid, instr, flush, out_ready, md_done,
        output in_ready, out_valid, branch, mem_read, mem_to_reg, mem_write,
               alu_src, reg_write, alu_ctrl, illegal, md_start, md_abort
    );

    modport master (
        output in_valid, instr, flush, out_ready, md_done,
        input  in_ready, out_valid, branch, mem_read, mem_to_reg, mem_write,
               alu_src, reg_write, alu_ctrl, illegal, md_start, md_abort
    );
endinterface

`default_nettype wire

// File: rtl/ctrl_decode_comb.sv
// ============================================================================
// Module      : ctrl_decode_comb
// Description : Pure combinational RV32IM instruction -> control word decode.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit EN_MEXT = 1'b1
) (
    input  logic [XLEN-1:0] instr,
    output ctrl_word_t      ctrl,
    output logic            is_md
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_bad;
    logic       w_unused_fields;

    assign w_opcode        = instr[6:0];
    assign w_funct3        = instr[14:12];
    assign w_funct7        = instr[31:25];
    assign w_unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        ctrl  = c_BUBBLE;
        is_md = 1'b0;
        w_bad = 1'b0;
        case (w_opcode)
            c_OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                case (w_funct7)
                    c_F7_BASE: begin
                        case (w_funct3)
                            3'b000:  ctrl.alu_ctrl = ALU_ADD;
                            3'b001:  ctrl.alu_ctrl = ALU_SLL;
                            3'b010:  ctrl.alu_ctrl = ALU_SLT;
                            3'b011:  ctrl.alu_ctrl = ALU_SLTU;
                            3'b100:  ctrl.alu_ctrl = ALU_XOR;
                            3'b101:  ctrl.alu_ctrl = ALU_SRL;
                            3'b110:  ctrl.alu_ctrl = ALU_OR;
                            default: ctrl.alu_ctrl = ALU_AND;
                        endcase
                    end
                    c_F7_ALT: begin
                        case (w_funct3)
                            3'b000:  ctrl.alu_ctrl = ALU_SUB;
                            3'b101:  ctrl.alu_ctrl = ALU_SRA;
                            default: w_bad = 1'b1;
                        endcase
                    end
                    c_F7_MEXT: begin
                        // mulh/mulhsu have no datapath support, so they trap
                        is_md = 1'b1;
                        if (EN_MEXT) begin
                            case (w_funct3)
                                3'b000:  ctrl.alu_ctrl = ALU_MUL;
                                3'b011:  ctrl.alu_ctrl = ALU_MULU;
                                3'b100:  ctrl.alu_ctrl = ALU_DIV;
                                3'b101:  ctrl.alu_ctrl = ALU_DIVU;
                                3'b110:  ctrl.alu_ctrl = ALU_REM;
                                3'b111:  ctrl.alu_ctrl = ALU_REMU;
                                default: w_bad = 1'b1;
                            endcase
                        end else begin
                            w_bad = 1'b1;
                        end
                    end
                    default: w_bad = 1'b1;
                endcase
            end
            c_OP_ICALC: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                case (w_funct3)
                    3'b000:  ctrl.alu_ctrl = ALU_ADD;
                    3'b010:  ctrl.alu_ctrl = ALU_SLT;
                    3'b011:  ctrl.alu_ctrl = ALU_SLTU;
                    3'b100:  ctrl.alu_ctrl = ALU_XOR;
                    3'b110:  ctrl.alu_ctrl = ALU_OR;
                    3'b111:  ctrl.alu_ctrl = ALU_AND;
                    3'b001: begin
                        ctrl.alu_ctrl = ALU_SLL;
                        w_bad         = (w_funct7 != c_F7_BASE);
                    end
                    default: begin
                        if (w_funct7 == c_F7_BASE)     ctrl.alu_ctrl = ALU_SRL;
                        else if (w_funct7 == c_F7_ALT) ctrl.alu_ctrl = ALU_SRA;
                        else                           w_bad = 1'b1;
                    end
                endcase
            end
            c_OP_LOAD: begin
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_ctrl   = ALU_ADD;
            end
            c_OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_ADD;
            end
            c_OP_BRANCH: begin
                ctrl.branch = 1'b1;
                case (w_funct3)
                    3'b000:  ctrl.alu_ctrl = ALU_BEQ;
                    3'b001:  ctrl.alu_ctrl = ALU_BNE;
                    3'b100:  ctrl.alu_ctrl = ALU_BLT;
                    3'b101:  ctrl.alu_ctrl = ALU_BGE;
                    3'b110:  ctrl.alu_ctrl = ALU_BLTU;
                    3'b111:  ctrl.alu_ctrl = ALU_BGEU;
                    default: w_bad = 1'b1;
                endcase
            end
            c_OP_JAL: begin
                ctrl.branch    = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = ALU_JAL;
            end
            c_OP_JALR: begin
                ctrl.branch    = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = ALU_JALR;
            end
            c_OP_AUIPC: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = ALU_AUIPC;
            end
            c_OP_LUI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = ALU_LUI;
            end
            default: w_bad = 1'b1;
        endcase

        if (w_bad) begin
            ctrl         = c_BUBBLE;
            ctrl.illegal = 1'b1;
            is_md        = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ctrl_decode_pipe.sv
// ============================================================================
// Module      : ctrl_decode_pipe
// Description : Registered ID/EX control stage with handshakes, flush and
//               mul/div start/done sequencing.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EN_MEXT   = 1'b1,
    parameter int ALUCTRL_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    ctrl_decode_pipe_if.slave  bus
);

    state_e     r_state;
    state_e     w_next;
    ctrl_word_t r_word;
    ctrl_word_t w_dec;
    ctrl_word_t w_out;
    logic       w_is_md;
    logic       w_in_ready;
    logic       w_accept;
    logic       r_md_start;

    ctrl_decode_comb #(
        .XLEN    (XLEN),
        .EN_MEXT (EN_MEXT)
    ) u_decode (
        .instr (bus.instr),
        .ctrl  (w_dec),
        .is_md (w_is_md)
    );

    assign w_in_ready = !bus.flush &&
                        ((r_state == ST_EMPTY) || ((r_state == ST_HOLD) && bus.out_ready));
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_EMPTY;
        else     r_state <= w_next;
    end

    // Start pulse lands in the first MD_WAIT cycle, right after the accept edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word     <= c_BUBBLE;
            r_md_start <= 1'b0;
        end else begin
            r_md_start <= w_accept && w_is_md;
            if (w_accept) r_word <= w_dec;
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.flush) begin
            w_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY:   if (w_accept) w_next = w_is_md ? ST_MD_WAIT : ST_HOLD;
                ST_HOLD:    if (bus.out_ready)
                                w_next = !w_accept ? ST_EMPTY :
                                         (w_is_md ? ST_MD_WAIT : ST_HOLD);
                ST_MD_WAIT: if (bus.md_done) w_next = ST_HOLD;
                default:    w_next = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_out         = c_BUBBLE;
        bus.out_valid = 1'b0;
        bus.md_abort  = 1'b0;
        case (r_state)
            ST_HOLD: begin
                bus.out_valid = 1'b1;
                w_out         = r_word;
            end
            ST_MD_WAIT: bus.md_abort = bus.flush;
            default: ;
        endcase
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.md_start   = r_md_start;
    assign bus.branch     = w_out.branch;
    assign bus.mem_read   = w_out.mem_read;
    assign bus.mem_to_reg = w_out.mem_to_reg;
    assign bus.mem_write  = w_out.mem_write;
    assign bus.alu_src    = w_out.alu_src;
    assign bus.reg_write  = w_out.reg_write;
    assign bus.illegal    = w_out.illegal;
    assign bus.alu_ctrl   = ALUCTRL_W'(w_out.alu_ctrl);

endmodule

`default_nettype wire
